hazard_scoreboard_unit: RTL
===========================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Next-gen pipeline hazard block: operand forwarding plus load-use and multi-cycle (MUL/DIV) scoreboard stalls.
//  Sits between the ID and EX stages; drives EX operand muxes, PC/IF-ID write enables and the ID/EX bubble.
//  Tracks up to MC_DEPTH outstanding long-latency writes per register.
//  Flags a stall that exceeds TIMEOUT cycles.
// PARAMETERS
//  NUM_REGS  32  architectural registers; x0 never busy/forwarded
//  RA_W      5   register address width, clog2(NUM_REGS)
//  MC_DEPTH  2   max outstanding multi-cycle ops (1..7)
//  TIMEOUT   64  consecutive SB_STALL cycles before hz_timeout
// PORTS
//  clk            in  1     clock, all state on rising edge
//  rst_n          in  1     synchronous active-low reset
//  id_rs1/id_rs2  in  RA_W  ID-stage source regs
//  id_use1/id_use2 in 1     ID instr really reads rs1/rs2
//  id_rd          in  RA_W  ID-stage dest reg
//  id_regwrite    in  1     ID instr writes rd
//  id_mc          in  1     ID instr is multi-cycle (issues to MUL/DIV)
//  ex_rs1/ex_rs2  in  RA_W  ID/EX-register sources
//  ex_rd          in  RA_W  ID/EX dest
//  ex_memread     in  1     ID/EX instr is a load
//  ex_is_store    in  1     ID/EX instr is a store (rs2 = store data)
//  exmem_rd       in  RA_W  EX/MEM dest
//  exmem_regwrite in  1     EX/MEM writes rd
//  memwb_rd       in  RA_W  MEM/WB dest
//  memwb_regwrite in  1     MEM/WB writes rd
//  mc_done        in  1     MUL/DIV writeback this cycle
//  mc_rd          in  RA_W  dest of completing op
//  flush          in  1     branch redirect; squashes the ID instr
//  forward_a      out 2     00 regfile, 01 EX/MEM, 10 MEM/WB (rs1)
//  forward_b      out 2     ALU rs2 select, same encoding
//  forward_c      out 2     store-data rs2 select, same encoding
//  ctrl_flush     out 1     insert bubble into ID/EX
//  pc_write       out 1     PC enable
//  fd_write       out 1     IF/ID enable
//  hz_timeout     out 1     sticky stall-watchdog error
//  lu_stall_cnt   out 32    load-use stall cycles (perf)
//  sb_stall_cnt   out 32    scoreboard stall cycles (perf)
// BEHAVIOUR
//  Forwarding (combinational): a source is matched only if nonzero; EX/MEM (exmem_regwrite) beats MEM/WB.
//   rs2 result goes to forward_c when ex_is_store=1 (forward_b=00), else to forward_b (forward_c=00).
//  Per-source conditions, each gated by id_useN, id_rsN!=0 and flush=0:
//   lu_haz = ex_memread && ex_rd!=0 && id_rsN==ex_rd.
//   sb_haz = busy[id_rsN] (RAW), busy[id_rd] when id_regwrite (WAW),
//            or id_mc && mc_cnt==MC_DEPTH && !mc_done (structural).
//  mc_done bypass: busy[mc_rd] and the mc_cnt slot are freed in the same cycle, for the hazard check.
//  stall = lu_haz|sb_haz  ->  ctrl_flush=1, pc_write=0, fd_write=0; else 0,1,1. Zero-cycle latency.
//  Scoreboard update on clk, when id_mc && id_regwrite && !stall && !flush && id_rd!=0:
//   set busy[id_rd], mc_cnt+1. On mc_done: clear busy[mc_rd], mc_cnt-1.
//   Both in one cycle: mc_cnt is unchanged; set wins when the regs are equal.
//   mc_done while mc_cnt==0 is ignored, no underflow.
//  FSM (registered, reports/watchdog only): RUN -> LU_STALL on lu_haz; RUN -> SB_STALL on sb_haz.
//   sb_haz has priority over lu_haz.
//   LU_STALL/SB_STALL -> RUN when stall drops. LU_STALL <-> SB_STALL follows the active cause.
//  Watchdog: wd_cnt increments each SB_STALL cycle and clears on leaving SB_STALL.
//   At wd_cnt==TIMEOUT-1 set hz_timeout, which stays set until reset.
//  flush: kills the current stall and the scoreboard set. It never clears busy bits (in-flight ops still write back).
//  Reset (rst_n=0 at clk): busy=0, mc_cnt=0, FSM=RUN, wd_cnt=0, hz_timeout=0, perf counters=0.
//   While rst_n=0 outputs are forced: forward_*=00, ctrl_flush=0, pc_write=1, fd_write=1.
//   A reset mid-MC-op drops all tracking; MUL/DIV is reset alongside.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: lu_stall_cnt/sb_stall_cnt count cycles in LU_STALL/SB_STALL and saturate at 2^32-1.
//  Not defined: both ports are tied to 32'h0 and no counter flops exist.
// TESTING
//  ex: lw x5; id: add x6,x5,x1 -> 1 stall cycle (ctrl_flush=1, pc_write=0), next cycle forward_a=10.
//  exmem_rd=x3 and memwb_rd=x3, both regwrite, ex_rs1=x3 -> forward_a=01; ex_rs1=x0 -> 00.
//  ex_is_store=1, ex_rs2=exmem_rd=x7 -> forward_c=01, forward_b=00.
//  Issue div x9 (mc_cnt=1); id reads x9 -> stalls until mc_done,mc_rd=9; same-cycle release, busy[9]=0.
//  MC_DEPTH=2, 2 ops outstanding, 3rd id_mc -> stalls; mc_done same cycle -> issues, mc_cnt stays 2.
//  mc_done withheld 64 cycles under SB_STALL -> hz_timeout=1 and stays set; rst_n=0 -> cleared.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   ID/EX hazard block: EX operand forwarding selects, load-use and
//   multi-cycle (MUL/DIV) scoreboard stalls, a reporting FSM with a
//   stall watchdog, and optional stall performance counters.
//   Optional feature macro: HAZ_PERF_CNT_EN (perf counters present when defined).
module hazard_scoreboard_unit #(
   parameter int NUM_REGS = 32,
   parameter int RA_W     = 5,
   parameter int MC_DEPTH = 2,
   parameter int TIMEOUT  = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   input  logic            id_use1,
   input  logic            id_use2,
   input  logic [RA_W-1:0] id_rd,
   input  logic            id_regwrite,
   input  logic            id_mc,
   input  logic [RA_W-1:0] ex_rs1,
   input  logic [RA_W-1:0] ex_rs2,
   input  logic [RA_W-1:0] ex_rd,
   input  logic            ex_memread,
   input  logic            ex_is_store,
   input  logic [RA_W-1:0] exmem_rd,
   input  logic            exmem_regwrite,
   input  logic [RA_W-1:0] memwb_rd,
   input  logic            memwb_regwrite,
   input  logic            mc_done,
   input  logic [RA_W-1:0] mc_rd,
   input  logic            flush,
   output logic [1:0]      forward_a,
   output logic [1:0]      forward_b,
   output logic [1:0]      forward_c,
   output logic            ctrl_flush,
   output logic            pc_write,
   output logic            fd_write,
   output logic            hz_timeout,
   output logic [31:0]     lu_stall_cnt,
   output logic [31:0]     sb_stall_cnt
);

   // MC_DEPTH is at most 7, so three bits hold the outstanding-op count
   localparam int MC_W = 3;
   localparam int WD_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_LU_STALL = 2'd1;
   localparam logic [1:0] ST_SB_STALL = 2'd2;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_busy_next;
   logic [NUM_REGS-1:0] w_rel_mask;
   logic [NUM_REGS-1:0] w_busy_eff;
   logic [MC_W-1:0]     r_mc_cnt;
   logic [MC_W-1:0]     w_mc_cnt_next;
   logic [1:0]          r_state;
   logic [1:0]          w_state_next;
   logic [WD_W-1:0]     r_wd_cnt;
   logic                r_hz_timeout;

   logic                w_release;
   logic                w_issue;
   logic                w_lu_haz1;
   logic                w_lu_haz2;
   logic                w_raw1;
   logic                w_raw2;
   logic                w_waw;
   logic                w_struct;
   logic                w_lu_haz;
   logic                w_sb_haz;
   logic                w_stall;
   logic [1:0]          w_fwd_rs1;
   logic [1:0]          w_fwd_rs2;

   // Source select for one EX operand; the younger EX/MEM result wins.
   function automatic logic [1:0] fwd_sel(
      input logic [RA_W-1:0] rs,
      input logic [RA_W-1:0] em_rd,
      input logic            em_we,
      input logic [RA_W-1:0] mw_rd,
      input logic            mw_we
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (rs != '0) begin
         if (em_we && (em_rd == rs))
            sel = FWD_EXMEM;
         else if (mw_we && (mw_rd == rs))
            sel = FWD_MEMWB;
      end
      return sel;
   endfunction

   // A writeback only counts when something is actually outstanding;
   // a stray mc_done with an empty scoreboard is ignored.
   assign w_release = mc_done && (r_mc_cnt != '0);

   // Per-register release mask and next busy vector; x0 is never tracked.
   // The issue term wins over the release term for the same register.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
         if (gi == 0) begin : g_x0
            assign w_rel_mask[gi]  = 1'b0;
            assign w_busy_next[gi] = 1'b0;
         end else begin : g_xn
            assign w_rel_mask[gi]  = w_release && (mc_rd == RA_W'(gi));
            assign w_busy_next[gi] = (w_issue && (id_rd == RA_W'(gi))) |
                                     (r_busy[gi] & ~w_rel_mask[gi]);
         end
      end
   endgenerate

   // A completing op releases its register in the same cycle for the check
   assign w_busy_eff = r_busy & ~w_rel_mask;

   // Hazard detection for the instruction sitting in ID
   always_comb begin
      w_lu_haz1 = id_use1 && (id_rs1 != '0) && !flush &&
                  ex_memread && (ex_rd != '0) && (id_rs1 == ex_rd);
      w_lu_haz2 = id_use2 && (id_rs2 != '0) && !flush &&
                  ex_memread && (ex_rd != '0) && (id_rs2 == ex_rd);
      w_raw1    = id_use1 && (id_rs1 != '0) && !flush && w_busy_eff[id_rs1];
      w_raw2    = id_use2 && (id_rs2 != '0) && !flush && w_busy_eff[id_rs2];
      w_waw     = id_regwrite && (id_rd != '0) && !flush && w_busy_eff[id_rd];
      w_struct  = id_mc && !flush && !mc_done &&
                  (r_mc_cnt == MC_W'(MC_DEPTH));
      w_lu_haz  = w_lu_haz1 | w_lu_haz2;
      w_sb_haz  = w_raw1 | w_raw2 | w_waw | w_struct;
      w_stall   = w_lu_haz | w_sb_haz;
      w_issue   = id_mc && id_regwrite && !w_stall && !flush && (id_rd != '0);
   end

   // Outstanding multi-cycle count: simultaneous issue and release cancel out
   always_comb begin
      w_mc_cnt_next = r_mc_cnt;
      unique case ({w_issue, w_release})
         2'b10:   w_mc_cnt_next = r_mc_cnt + MC_W'(1);
         2'b01:   w_mc_cnt_next = r_mc_cnt - MC_W'(1);
         default: w_mc_cnt_next = r_mc_cnt;
      endcase
   end

   // Scoreboard state; reset drops all tracking (MUL/DIV resets alongside)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy   <= '0;
         r_mc_cnt <= '0;
      end else begin
         r_busy   <= w_busy_next;
         r_mc_cnt <= w_mc_cnt_next;
      end
   end

   // Reporting FSM next state; a scoreboard cause outranks a load-use cause
   always_comb begin
      w_state_next = ST_RUN;
      if (w_sb_haz)
         w_state_next = ST_SB_STALL;
      else if (w_lu_haz)
         w_state_next = ST_LU_STALL;
   end

   // Reporting FSM register
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= ST_RUN;
      else
         r_state <= w_state_next;
   end

   // Stall watchdog: counts cycles spent in SB_STALL, sticky error flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wd_cnt     <= '0;
         r_hz_timeout <= 1'b0;
      end else if (r_state == ST_SB_STALL) begin
         if (r_wd_cnt == WD_W'(TIMEOUT - 1))
            r_hz_timeout <= 1'b1;
         else
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end else begin
         r_wd_cnt <= '0;
      end
   end

   assign hz_timeout = r_hz_timeout;

   // Forwarding selects and pipeline control; forced benign while in reset
   always_comb begin
      w_fwd_rs1  = fwd_sel(ex_rs1, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
      w_fwd_rs2  = fwd_sel(ex_rs2, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
      forward_a  = FWD_RF;
      forward_b  = FWD_RF;
      forward_c  = FWD_RF;
      ctrl_flush = 1'b0;
      pc_write   = 1'b1;
      fd_write   = 1'b1;
      if (rst_n) begin
         forward_a = w_fwd_rs1;
         if (ex_is_store)
            forward_c = w_fwd_rs2;
         else
            forward_b = w_fwd_rs2;
         ctrl_flush = w_stall;
         pc_write   = !w_stall;
         fd_write   = !w_stall;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] r_lu_cnt;
   logic [31:0] r_sb_cnt;

   // Saturating per-cause stall cycle counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lu_cnt <= '0;
         r_sb_cnt <= '0;
      end else begin
         if ((r_state == ST_LU_STALL) && (r_lu_cnt != 32'hFFFF_FFFF))
            r_lu_cnt <= r_lu_cnt + 32'd1;
         if ((r_state == ST_SB_STALL) && (r_sb_cnt != 32'hFFFF_FFFF))
            r_sb_cnt <= r_sb_cnt + 32'd1;
      end
   end

   assign lu_stall_cnt = r_lu_cnt;
   assign sb_stall_cnt = r_sb_cnt;
`else
   assign lu_stall_cnt = 32'h0;
   assign sb_stall_cnt = 32'h0;
`endif

endmodule
